// File: rtl/fifo_rd_adapter.sv
// Read-side adapter: pops a registered-read FIFO and streams the
// words out on valid/ready through a 2-entry ring buffer.
`timescale 1ns/1ps
module fifo_rd_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  xfer_count
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic                  discard_q, discard_d;
  logic [CNT_WIDTH-1:0]  xfer_q, xfer_d;

  logic       pop;
  logic       capture;
  logic       credit;
  logic [2:0] pending;

  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = mem_q[rd_ptr_q];
  assign xfer_count = xfer_q;
  assign pop        = m_valid & m_ready;

  // Words owed to the buffer: stored ones plus the one on the bus.
  assign pending = {1'b0, occ_q} + {2'b00, inflight_q};
  assign credit  = pending < (3'd2 + {2'b00, pop});

  assign fifo_rd_en = rst & ~flush & ~fifo_empty & credit;
  assign capture    = inflight_q & ~discard_q & ~flush;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    inflight_d = fifo_rd_en;
    discard_d  = discard_q;
    xfer_d     = xfer_q;

    if (inflight_q && discard_q) begin
      discard_d = 1'b0;
    end
    if (capture) begin
      mem_d[wr_ptr_q] = fifo_rd_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      xfer_d   = xfer_q + CNT_WIDTH'(1);
    end
    occ_d = occ_q + 2'(capture) - 2'(pop);

    // A pop in the flush cycle still counts; everything else drops.
    if (flush) begin
      occ_d      = 2'd0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
      xfer_q     <= '0;
    end else begin
      mem_q[0]   <= mem_d[0];
      mem_q[1]   <= mem_d[1];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      xfer_q     <= xfer_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Bench for fifo_rd_adapter: FIFO model upstream, in-order word
// scoreboard with 2-cycle latency rule, plus directed scenarios.
`timescale 1ns/1ps
module tb_fifo_rd_adapter;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_empty = 1'b1;
  logic          flush = 1'b0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic [CW-1:0] xfer_count;

  logic          push = 1'b0;
  logic [DW-1:0] push_d = '0;

  typedef struct {
    int          t;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          pending[$];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] got_q[$];
  int            got_t[$];
  int            pop_t[$];
  int            cyc = 0;
  int            cnt = 0;
  int            vectors = 0;
  int            miscompares = 0;

  fifo_rd_adapter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .rst(rst),
    .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty),
    .flush(flush),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_ready(m_ready),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  // A word popped in cycle N is visible from cycle N+2 until taken.
  function automatic bit exp_valid();
    return pending.size() != 0 && pending[0].t + 2 <= cyc;
  endfunction

  function automatic bit exp_rd_en();
    int p;
    p = (exp_valid() && m_ready) ? 1 : 0;
    return rst && !flush && !fifo_empty && (pending.size() - p < 2);
  endfunction

  always @(negedge rst) begin
    pending.delete();
    cnt = 0;
  end

  // Upstream FIFO with one-cycle registered read, plus reference model.
  always @(posedge clk) begin
    logic [DW-1:0] w;
    if (!rst) begin
      pending.delete();
      cnt = 0;
    end else begin
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        got_t.push_back(cyc);
      end
      if (exp_valid() && m_ready) begin
        void'(pending.pop_front());
        cnt++;
      end
      if (flush) pending.delete();
    end
    if (fifo_rd_en && fifo_q.size() != 0) begin
      w = fifo_q.pop_front();
      fifo_rd_data <= w;
      pending.push_back('{t: cyc, d: w});
      pop_t.push_back(cyc);
    end
    if (push) fifo_q.push_back(push_d);
    fifo_empty <= (fifo_q.size() == 0);
    cyc++;
  end

  always @(negedge clk) begin
    #1;
    vectors++;
    if (!rst) begin
      if (m_valid !== 1'b0 || m_data !== '0 ||
          fifo_rd_en !== 1'b0 || xfer_count !== '0) begin
        miscompares++;
        $display("FAIL reset_out cyc=%0d: v=%b d=%h en=%b cnt=%0d want 0",
                 cyc, m_valid, m_data, fifo_rd_en, xfer_count);
      end
    end else begin
      if (m_valid !== exp_valid()) begin
        miscompares++;
        $display("FAIL m_valid cyc=%0d: got %b want %b",
                 cyc, m_valid, exp_valid());
      end else if (exp_valid() && m_data !== pending[0].d) begin
        miscompares++;
        $display("FAIL m_data cyc=%0d: got %h want %h",
                 cyc, m_data, pending[0].d);
      end
      if (fifo_rd_en !== exp_rd_en()) begin
        miscompares++;
        $display("FAIL rd_en cyc=%0d: got %b want %b",
                 cyc, fifo_rd_en, exp_rd_en());
      end
      if (xfer_count !== CW'(cnt)) begin
        miscompares++;
        $display("FAIL xfer_count cyc=%0d: got %0d want %0d",
                 cyc, xfer_count, CW'(cnt));
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input bit p, input logic [DW-1:0] d);
    @(negedge clk);
    push   = p;
    push_d = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  int l0, p0, hold;

  initial begin
    // Streaming: preload 1..8 while held in reset.
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i));
    idle(2);
    #2;
    chk("reset_m_data", int'(m_data), 0);
    chk("reset_rd_en", int'(fifo_rd_en), 0);
    l0 = got_q.size();
    p0 = pop_t.size();
    @(negedge clk);
    rst  = 1'b1;
    push = 1'b0;
    idle(14);
    chk("stream_pops", pop_t.size() - p0, 8);
    chk("stream_pop_span", pop_t[p0 + 7] - pop_t[p0], 7);
    chk("stream_latency", got_t[l0] - pop_t[p0], 2);
    chk("stream_xfer_span", got_t[l0 + 7] - got_t[l0], 7);
    for (int i = 0; i < 8; i++)
      chk("stream_word", int'(got_q[l0 + i]), i + 1);
    chk("stream_count", int'(xfer_count), 8);

    // Back-pressure.
    l0 = got_q.size();
    p0 = pop_t.size();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h21 + i));
    idle(6);
    #2;
    chk("bp_pops", pop_t.size() - p0, 2);
    chk("bp_valid", int'(m_valid), 1);
    chk("bp_data", int'(m_data), 'h21);
    m_ready = 1'b1;
    idle(12);
    chk("bp_delivered", got_q.size() - l0, 5);
    for (int i = 0; i < 5; i++)
      chk("bp_word", int'(got_q[l0 + i]), 'h21 + i);

    // Empty FIFO.
    p0 = pop_t.size();
    l0 = got_q.size();
    idle(10);
    #2;
    chk("empty_pops", pop_t.size() - p0, 0);
    chk("empty_valid", int'(m_valid), 0);
    step(1'b1, 8'hA5);
    idle(5);
    chk("a5_count", got_q.size() - l0, 1);
    chk("a5_word", int'(got_q[got_q.size() - 1]), 'hA5);

    // Flush with both buffer slots full.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, DW'(8'h31 + i));
    idle(4);
    l0 = got_q.size();
    @(negedge clk);
    push  = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #2;
    chk("flush_valid", int'(m_valid), 0);
    m_ready = 1'b1;
    idle(10);
    chk("flush_delivered", got_q.size() - l0, 2);
    chk("flush_next0", int'(got_q[l0]), 'h33);
    chk("flush_next1", int'(got_q[l0 + 1]), 'h34);

    // Reset mid-transfer, then counter wrap.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h41 + i));
    idle(4);
    @(negedge clk);
    push = 1'b0;
    rst  = 1'b0;
    #2;
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_rd_en", int'(fifo_rd_en), 0);
    chk("rst_count", int'(xfer_count), 0);
    m_ready = 1'b1;
    idle(2);
    l0 = got_q.size();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b1, DW'(8'h50 + i));
    idle(8);
    chk("rst_first_word", int'(got_q[l0]), 'h43);
    chk("wrap_count", int'(xfer_count), 1);

    // Randomized traffic.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 6, DW'($urandom));
      m_ready = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 19) == 0);
      if (hold > 0) begin
        hold--;
        rst = (hold == 0);
      end else if ($urandom_range(0, 299) == 0) begin
        hold = 2;
        rst  = 1'b0;
      end
    end

    // Drain.
    @(negedge clk);
    push    = 1'b0;
    flush   = 1'b0;
    rst     = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (fifo_q.size() == 0 && pending.size() == 0) break;
      idle(1);
    end
    idle(3);
    #2;
    chk("drain_fifo", fifo_q.size(), 0);
    chk("drain_pending", pending.size(), 0);
    chk("drain_valid", int'(m_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
